// File: rtl/eth_mii_tx.sv
// ---------------------------------------------------------------------------
// eth_mii_tx
//
// Frame transmitter on the read side of the Ethernet TX byte buffer. When the
// control logic issues a send request, this block reads bytes out of the
// buffer and serialises them onto a 4-bit MII-style transmit interface.
// The sequence is preamble, SFD, payload, zero padding up to MIN_FRAME, the
// CRC32 FCS and then the inter-frame gap. At the end of the gap, or when a
// request is rejected, it signals completion.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle send request, accepted only while idle
//   txsize     frame length in bytes excluding FCS, sampled on accept
//   nib_ce     nibble-slot strobe, never high on two consecutive cycles
//   buf_addr   byte read address into the TX buffer
//   buf_rdata  buffer read data, valid one clk after buf_addr changes
//   txd        transmit nibble
//   tx_en      transmit enable
//   busy       high from accepted start until the end of the gap
//   done       one-clk completion pulse (end of gap, or rejection)
//   err        set with done when txsize exceeds MTU, cleared on next accept
//
// IFG_NIBBLES is expected to be at least 1. The drop of tx_en happens on the
// first gap slot.
// ---------------------------------------------------------------------------
module eth_mii_tx #(
    parameter int MTU         = 1536,
    parameter int MIN_FRAME   = 60,
    parameter int IFG_NIBBLES = 24,
    parameter int W_ADDR      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       txsize,
    input  logic              nib_ce,
    output logic [W_ADDR-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [3:0]        txd,
    output logic              tx_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REJECT,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t            state, state_d;
    logic [15:0]       cnt, cnt_d;          // slot counter for PRE/FCS/IFG
    logic [15:0]       byte_cnt, byte_cnt_d; // bytes completed in DATA+PAD
    logic              high_half, high_half_d;
    logic [15:0]       len, len_d;
    logic [7:0]        hold, hold_d;         // byte currently being sent
    logic [31:0]       crc, crc_d;
    logic [W_ADDR-1:0] buf_addr_d;
    logic [3:0]        txd_d;
    logic              tx_en_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state and next-output logic. Every transmit-side change is gated
    // by nib_ce so there is exactly one nibble per strobe.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d     = state;
        cnt_d       = cnt;
        byte_cnt_d  = byte_cnt;
        high_half_d = high_half;
        len_d       = len;
        hold_d      = hold;
        crc_d       = crc;
        buf_addr_d  = buf_addr;
        txd_d       = txd;
        tx_en_d     = tx_en;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    len_d       = txsize;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    buf_addr_d  = '0;
                    crc_d       = CRC_INIT;
                    cnt_d       = '0;
                    byte_cnt_d  = '0;
                    high_half_d = 1'b0;
                    state_d     = (int'(txsize) > MTU) ? S_REJECT : S_PRE;
                end
            end

            // Oversized request: report it one clk after accept, never transmit.
            S_REJECT: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_PRE: begin
                if (nib_ce) begin
                    txd_d   = 4'h5;
                    tx_en_d = 1'b1;
                    if (cnt == 16'd14) begin
                        cnt_d   = '0;
                        state_d = S_SFD;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end

            // buf_addr has been 0 since accept, so byte 0 is long settled.
            S_SFD: begin
                if (nib_ce) begin
                    txd_d  = 4'hD;
                    hold_d = buf_rdata;
                    if (len != 16'd0) begin
                        state_d = S_DATA;
                    end else if (MIN_FRAME > 0) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FCS;
                    end
                end
            end

            // Low nibble first. The address advances right after the low
            // nibble; the strobe spacing guarantees the next byte is on
            // buf_rdata by the high-nibble strobe, where it is captured.
            S_DATA: begin
                if (nib_ce) begin
                    if (!high_half) begin
                        txd_d       = hold[3:0];
                        high_half_d = 1'b1;
                        if (byte_cnt != len - 16'd1) begin
                            buf_addr_d = buf_addr + W_ADDR'(1);
                        end
                    end else begin
                        txd_d       = hold[7:4];
                        high_half_d = 1'b0;
                        crc_d       = crc_byte(crc, hold);
                        hold_d      = buf_rdata;
                        byte_cnt_d  = byte_cnt + 16'd1;
                        if (byte_cnt == len - 16'd1) begin
                            state_d = (int'(len) < MIN_FRAME) ? S_PAD : S_FCS;
                        end
                    end
                end
            end

            // byte_cnt keeps counting from the payload so padding stops at
            // MIN_FRAME total bytes.
            S_PAD: begin
                if (nib_ce) begin
                    txd_d = 4'h0;
                    if (!high_half) begin
                        high_half_d = 1'b1;
                    end else begin
                        high_half_d = 1'b0;
                        crc_d       = crc_byte(crc, 8'h00);
                        byte_cnt_d  = byte_cnt + 16'd1;
                        if (int'(byte_cnt) == MIN_FRAME - 1) begin
                            state_d = S_FCS;
                        end
                    end
                end
            end

            // FCS is the complemented CRC, least significant nibble first.
            S_FCS: begin
                if (nib_ce) begin
                    txd_d = ~crc[{cnt[2:0], 2'b00} +: 4];
                    if (cnt == 16'd7) begin
                        cnt_d   = '0;
                        state_d = S_IFG;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end

            S_IFG: begin
                if (nib_ce) begin
                    txd_d   = 4'h0;
                    tx_en_d = 1'b0;
                    if (int'(cnt) == IFG_NIBBLES - 1) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Asynchronous reset aborts any frame at once; tx_en drops with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            byte_cnt  <= '0;
            high_half <= 1'b0;
            len       <= '0;
            hold      <= '0;
            crc       <= CRC_INIT;
            buf_addr  <= '0;
            txd       <= '0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state     <= state_d;
            cnt       <= cnt_d;
            byte_cnt  <= byte_cnt_d;
            high_half <= high_half_d;
            len       <= len_d;
            hold      <= hold_d;
            crc       <= crc_d;
            buf_addr  <= buf_addr_d;
            txd       <= txd_d;
            tx_en     <= tx_en_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: doc/eth_mii_tx.md
Name: eth_mii_tx

Overview:
- Frame transmitter on the read side of the Ethernet TX byte buffer.
- The APB control logic fills the buffer and issues a send request. This block then reads bytes from the buffer and drives a 4-bit MII-style transmit interface: preamble, SFD, payload, zero padding, CRC32 FCS, then inter-frame gap.
- It is the real-hardware replacement for the simulation-only send path, and it raises the TX-complete event.

Parameters:
- MTU, 1536: buffer depth in bytes; largest legal txsize.
- MIN_FRAME, 60: minimum payload+pad bytes before FCS; 0 disables padding.
- IFG_NIBBLES, 24: tx_en-low nibble slots after FCS before the block returns to idle.
- W_ADDR, 32: width of buf_addr.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle send request from the control FSM.
- txsize  in  16  frame length in bytes, excluding FCS; sampled when start is accepted.
- nib_ce  in  1  nibble-slot strobe. Never high on two consecutive clk cycles.
- buf_addr  out  W_ADDR  byte read address into the TX buffer.
- buf_rdata  in  8  buffer read data; valid exactly 1 clk after buf_addr changes.
- txd  out  4  transmit nibble.
- tx_en  out  1  transmit enable.
- busy  out  1  high from accepted start until the end of IFG.
- done  out  1  one-clk pulse at the end of IFG, or on rejection.
- err  out  1  set with done when txsize > MTU; cleared by the next accepted start.

Behaviour:
- Reset values: txd=0, tx_en=0, busy=0, done=0, err=0, buf_addr=0, state=IDLE, CRC register=32'hFFFFFFFF. Reset mid-frame aborts immediately; tx_en drops asynchronously with reset.
- start is accepted only in IDLE. start while busy is ignored, with no side effects.
- On accept:
  - Latch len=txsize, set busy=1, clear err, set buf_addr=0.
  - If len > MTU: do not transmit; pulse done with err=1 on the next clk; busy returns to 0 on that same clk.
- txd and tx_en change only on clk edges where nib_ce=1. Every state advance occurs on nib_ce, so there is one nibble per strobe.
- States:
  - IDLE: tx_en=0, txd=0.
  - PRE: 15 nibbles of 4'h5, tx_en=1.
  - SFD: 1 nibble of 4'hD.
  - DATA: for each byte i < len, low nibble first, then high nibble. buf_addr increments after the low nibble is emitted; the next byte is latched into a holding register before the following strobe, which is guaranteed by the nib_ce spacing. buf_addr wraps only via len, never past MTU-1.
  - PAD: if len < MIN_FRAME, emit (MIN_FRAME-len) zero bytes, each as 2 nibbles of 0. len=0 is legal and yields MIN_FRAME pad bytes.
  - FCS: 8 nibbles of ~crc, in order crc[3:0], [7:4], ..., [31:28], with each nibble inverted.
  - IFG: tx_en=0, txd=0 for IFG_NIBBLES strobes. On the last one: done=1 for one clk, busy=0, next state IDLE.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, init FFFFFFFF. Updated over every DATA and PAD byte, never over preamble or SFD, one byte per completed high nibble. Reinitialised on each accepted start.
- Frame length: tx_en is high for exactly 16 + 2*max(len, MIN_FRAME) + 8 consecutive nib_ce slots.
- nib_ce stuck low: state holds indefinitely. No timeout.

Test Plan:
- MIN_FRAME=0; buffer holds ASCII "123456789"; start with txsize=9.
  - Required: 15×5, then D, then nibbles 1,3,2,3,...,9,3.
  - FCS nibbles 6,2,9,3,4,F,B,C (FCS 0xCBF43926).
  - tx_en high for 42 slots; done after 24 idle slots.
- MIN_FRAME=60, txsize=0 -> 16 header nibbles, then 120 zero nibbles, then 8 FCS nibbles. tx_en high for 144 slots. FCS matches the bench CRC model of 60 zero bytes.
- txsize=1600 (> MTU) -> tx_en never asserts; done and err high on the clk after start; busy low by then.
- Second start during DATA -> ignored; the frame completes unchanged and only one done pulse occurs.
- Assert rst_n low mid-DATA -> tx_en=0 and busy=0 immediately. A subsequent start with txsize=9 transmits a correct frame whose FCS is unaffected by the aborted frame.
- nib_ce every 2nd clk versus every 5th clk with a 1518-byte frame -> identical nibble sequence. buf_addr reaches 1517 and never exceeds it.
